// File: rtl/blk_mem_arbiter_pkg.sv
// ============================================================================
// blk_mem_arbiter_pkg : shared index-width, round-robin and slice helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package blk_mem_arbiter_pkg;

    localparam int C_MIN_REQ = 2;
    localparam int C_MAX_REQ = 8;

    function automatic int req_idx_w(input int num_req);
        return $clog2(num_req);
    endfunction

    // Pointer moves just past the last winner so it gets lowest priority next.
    function automatic int rr_next(input int k, input int num_req);
        return (k + 1 >= num_req) ? 0 : k + 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blk_mem.sv
// ============================================================================
// blk_mem : simple dual-port RAM, one write port and one registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module blk_mem #(
    parameter int BIT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [BIT_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    output logic [BIT_WIDTH-1:0]  rd_data
);

    logic [BIT_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    // Read-before-write: a same-address read in the write cycle sees old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr_in] <= wr_data;
        end
        rd_data <= r_mem[addr_out];
    end

endmodule

`default_nettype wire

// File: rtl/blk_mem_arbiter_rr_arb.sv
// ============================================================================
// rr_arb : combinational round-robin arbiter, search starts at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb
    import blk_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = req_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    int w_cand;

    // Walk the ring backwards so the candidate closest to ptr is written last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_cand  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = int'(ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (req[IDX_W'(w_cand)]) begin
                gnt                  = '0;
                gnt[IDX_W'(w_cand)]  = 1'b1;
                gnt_idx              = IDX_W'(w_cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/blk_mem_arbiter.sv
// ============================================================================
// blk_mem_arbiter : independent round-robin write/read sharing of one blk_mem
// Rev 1.0
// ============================================================================
`default_nettype none

module blk_mem_arbiter
    import blk_mem_arbiter_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]  wr_data,
    output logic [NUM_REQ-1:0]            wr_gnt,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [BIT_WIDTH-1:0]          rd_data
);

    localparam int IDX_W = req_idx_w(NUM_REQ);

    logic [IDX_W-1:0]      r_wr_ptr;
    logic [IDX_W-1:0]      r_rd_ptr;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [NUM_REQ-1:0]    w_wr_req;
    logic [NUM_REQ-1:0]    w_rd_req;
    logic [NUM_REQ-1:0]    r_rd_tag;
    logic                  w_wr_any;
    logic                  w_rd_any;
    logic [ADDR_WIDTH-1:0] w_mem_wr_addr;
    logic [BIT_WIDTH-1:0]  w_mem_wr_data;
    logic [ADDR_WIDTH-1:0] w_mem_rd_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr_hold;

    // Masking requests keeps both grants low for the whole reset interval.
    assign w_wr_req = wr_req & {NUM_REQ{rst_n}};
    assign w_rd_req = rd_req & {NUM_REQ{rst_n}};

    rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_wr_arb (
        .req     (w_wr_req),
        .ptr     (r_wr_ptr),
        .gnt     (wr_gnt),
        .gnt_idx (w_wr_idx)
    );

    rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rd_arb (
        .req     (w_rd_req),
        .ptr     (r_rd_ptr),
        .gnt     (rd_gnt),
        .gnt_idx (w_rd_idx)
    );

    assign w_wr_any = |wr_gnt;
    assign w_rd_any = |rd_gnt;

    always_comb begin
        w_mem_wr_addr = '0;
        w_mem_wr_data = '0;
        w_mem_rd_addr = r_rd_addr_hold;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                w_mem_wr_addr = wr_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
                w_mem_wr_data = wr_data[slice_lo(i, BIT_WIDTH) +: BIT_WIDTH];
            end
            if (rd_gnt[i]) begin
                w_mem_rd_addr = rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_rd_tag       <= '0;
            r_rd_addr_hold <= '0;
        end else begin
            if (w_wr_any) begin
                r_wr_ptr <= IDX_W'(rr_next(int'(w_wr_idx), NUM_REQ));
            end
            if (w_rd_any) begin
                r_rd_ptr <= IDX_W'(rr_next(int'(w_rd_idx), NUM_REQ));
            end
            r_rd_addr_hold <= w_mem_rd_addr;
            r_rd_tag       <= rd_gnt;
        end
    end

    assign rd_valid = r_rd_tag;

    blk_mem #(.BIT_WIDTH(BIT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk      (clk),
        .wr_en    (w_wr_any),
        .addr_in  (w_mem_wr_addr),
        .wr_data  (w_mem_wr_data),
        .addr_out (w_mem_rd_addr),
        .rd_data  (rd_data)
    );

endmodule

`default_nettype wire

// File: doc/blk_mem_arbiter.md
Name: blk_mem_arbiter

Overview:
- Shares one blk_mem instance between NUM_REQ requesters, for example a DMA writer and several convolution line readers in the fish-box image pipeline.
- The write port and the read port are arbitrated independently, each round-robin, so one write and one read can reach memory in the same cycle.
- Read data returns on a shared bus, qualified by a one-hot valid that identifies the requester.

Parameters:
- BIT_WIDTH, 8, data word width passed to blk_mem.
- ADDR_WIDTH, 4, address width passed to blk_mem (depth 1<<ADDR_WIDTH).
- NUM_REQ, 2, number of requesters; legal range 2..8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  NUM_REQ  per-requester write request.
- wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses; requester i uses slice i.
- wr_data  in  NUM_REQ*BIT_WIDTH  packed write data.
- wr_gnt  out  NUM_REQ  one-hot write grant, combinational from the inputs and pointer.
- rd_req  in  NUM_REQ  per-requester read request.
- rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses.
- rd_gnt  out  NUM_REQ  one-hot read grant, combinational.
- rd_valid  out  NUM_REQ  one-hot, registered; marks rd_data as belonging to requester i.
- rd_data  out  BIT_WIDTH  shared read data bus.

Behaviour:
- Reset (async, active-low): wr_ptr=0 and rd_ptr=0, giving requester 0 top priority. rd_valid=0 and the pending-tag register is cleared. rd_gnt/wr_gnt are 0 while rst_n=0.
- Handshake: a requester holds its req, addr and data stable until it sees gnt high at a rising edge. The transfer occurs on that edge. A req dropped before grant is legal; nothing is issued.
- Arbitration: for each port, grant the first requester with req set, searching from ptr, ptr+1, ... modulo NUM_REQ. At most one grant per port per cycle. With no requests, no grant and no memory access.
- Pointer update: on an edge with a grant to requester k, ptr <= (k+1) mod NUM_REQ. Otherwise ptr holds. The write pointer and read pointer are fully independent.
- Write path: blk_mem.wr_en = |wr_gnt. addr_in and wr_data are muxed from the granted slice. Memory is updated at the grant edge.
- Read path: addr_out is muxed from the granted slice, or held at the last address when idle. The tag register latches rd_gnt at each edge.
- Read latency: grant in cycle T means blk_mem registers the data at edge T->T+1. rd_valid[k]=1 and rd_data are valid during cycle T+1.
- Back-to-back reads: a requester may be granted every cycle, giving full throughput with one response per cycle.
- rd_data is passed through from blk_mem unchanged. It is meaningful only while rd_valid is nonzero and is don't-care otherwise.
- Same-address read and write in the same cycle: the read returns the OLD data. There is no forwarding; requesters must order such accesses themselves.
- Reset mid-operation: an outstanding read response is dropped, with rd_valid forced to 0 immediately and asynchronously. Memory contents after reset are undefined to clients and must be rewritten before reading.
- Out-of-range address: none possible; all 2^ADDR_WIDTH addresses are legal.

Decomposition:
- Shared package:
  - Request-index width constant, clog2(NUM_REQ).
  - Round-robin next-pointer function.
  - Packed-slice helper for addr/data extraction.
- One sub-module rr_arb (NUM_REQ parameter; req, ptr in; one-hot gnt, gnt_idx out). It is instantiated twice, once for write and once for read.
- blk_mem is instantiated once inside this block.

Test Plan:
- Single write then read: write req0 addr 3 data 0xA5, then read req1 addr 3. Expect rd_valid=2'b10 with rd_data=0xA5 exactly one cycle after rd_gnt[1].
- Contention fairness: hold rd_req=2'b11 for 6 cycles on addrs 1 and 2. Expect rd_gnt to alternate 01,10,01,10,01,10 and rd_valid to follow one cycle later.
- Concurrent ports: same cycle, wr req0 addr 5 data 0x3C and rd req1 addr 5 (old value 0x11). Expect both granted, read returns 0x11, and a subsequent read returns 0x3C.
- Pointer independence: write contention on requester 1 only, then both write and read requests together. Expect the write grant to go to requester 0 (wr_ptr advanced) while the read grant follows rd_ptr=0.
- Back-to-back throughput: req0 reads addrs 0..15 on consecutive cycles after a prefill of data = addr^0xFF. Expect 16 consecutive rd_valid=01 cycles with correct data.
- Reset mid-read: assert rst_n=0 in the cycle after a read grant. Expect rd_valid=0 immediately, and after release the first grant goes to requester 0.
